// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM encodings and width helper for the shift-add multiplier
package mult_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/nBitRippleCarryAdder.sv
// nBitRippleCarryAdder: n-bit unsigned ripple-carry adder with carry-out as total[n]
module nBitRippleCarryAdder #(
  parameter int n = 4
) (
  output logic [n:0]   total,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B
);
  logic [n:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < n; i++) begin : g_fa
    assign total[i] = A[i] ^ B[i] ^ c[i];
    assign c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign total[n] = c[n];
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned N x N shift-and-add multiplier with start/ready/done
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [2*N-1:0] product
);
  localparam int CW = cw_of(N);
  logic [1:0]    state;
  logic [N-1:0]  m;
  logic [N-1:0]  p_hi;
  logic [N-1:0]  q;
  logic [CW-1:0] count;
  logic [N-1:0]  addend;
  logic [N:0]    total;
  assign addend = q[0] ? m : '0;
  assign ready  = state == IDLE;
  assign done   = state == DONE;
  nBitRippleCarryAdder #(.n(N)) u_add (
    .total(total),
    .A(p_hi),
    .B(addend)
  );
  // FSM plus shift register: each RUN step adds, then shifts {carry,sum,Q} right by one
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      m       <= '0;
      p_hi    <= '0;
      q       <= '0;
      count   <= '0;
      product <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        m     <= a;
        q     <= b;
        p_hi  <= '0;
        count <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      p_hi  <= total[N:1];
      q     <= {total[0], q[N-1:1]};
      count <= count + 1'b1;
      if (count == CW'(N - 1)) begin
        product <= {total, q[N-1:1]};
        state   <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: scoreboard bench, random and exhaustive operands vs a*b model
module tb_shift_add_multiplier;
  localparam int N = 4;
  logic clk = 0;
  logic reset = 1;
  logic start = 0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic ready;
  logic done;
  logic [2*N-1:0] product;
  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [2*N-1:0] exp_q[$];
  logic rst_prev = 1;
  logic [2*N-1:0] prev_prod = '0;

  shift_add_multiplier #(.N(N)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(a),
    .b(b),
    .ready(ready),
    .done(done),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: reset state after a sampled reset, scoreboard pop on done, product hold otherwise
  always @(negedge clk) begin
    if (rst_prev) begin
      chk(ready === 1'b1 && done === 1'b0, "reset_ctrl", {14'd0, ready, done}, 16'h2);
      chk(product === '0, "reset_product", 16'(product), 16'h0);
    end else if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_done", 16'(product), 16'hFFFF);
      end else begin
        logic [2*N-1:0] e;
        e = exp_q.pop_front();
        chk(product === e, "product", 16'(product), 16'(e));
      end
    end else begin
      chk(product === prev_prod, "product_hold", 16'(product), 16'(prev_prod));
    end
    rst_prev = reset;
    prev_prod = product;
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk(1'b0, "ready_timeout", 16'(ready), 16'h1);
  endtask

  task automatic op(input logic [N-1:0] x, input logic [N-1:0] y);
    int lat = 0;
    wait_ready();
    a = x;
    b = y;
    start = 1;
    exp_q.push_back(8'(x) * 8'(y));
    @(posedge clk);
    #1 start = 0;
    a = $urandom;
    b = $urandom;
    chk(ready === 1'b0, "ready_fall", 16'(ready), 16'h0);
    do begin
      @(posedge clk);
      #1 lat++;
    end while (done !== 1'b1 && lat < 20);
    chk(lat == N, "latency", 16'(lat), 16'(N));
    @(posedge clk);
    #1 chk(done === 1'b0 && ready === 1'b1, "done_pulse_ready", {14'd0, done, ready}, 16'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    time t0, t1;
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    op(0, 0);
    op(15, 15);
    op(13, 11);
    op(1, 0);
    wait_ready();
    start = 1;
    a = 3;
    b = 5;
    exp_q.push_back(8'd15);
    @(posedge clk);
    t0 = $time;
    #1 a = 7;
    b = 9;
    wait_ready();
    exp_q.push_back(8'd63);
    @(posedge clk);
    t1 = $time;
    #1 start = 0;
    chk((t1 - t0) == 60, "held_start_period", 16'(t1 - t0), 16'd60);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk(done === 1'b1, "held_done", 16'(done), 16'h1);
    wait_ready();
    a = 12;
    b = 12;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    @(posedge clk);
    #1 reset = 1;
    start = 1;
    @(posedge clk);
    #1 reset = 0;
    start = 0;
    chk(ready === 1'b1 && product === '0, "abort_state", {7'd0, ready, product}, 16'h100);
    repeat (N + 3) @(posedge clk);
    op(2, 3);
    repeat (20) op(4'($urandom), 4'($urandom));
    done_cnt = 0;
    for (int i = 0; i < 256; i++) op(4'(i >> 4), 4'(i));
    repeat (2) @(posedge clk);
    chk(done_cnt == 256, "sweep_done_count", 16'(done_cnt), 16'd256);
    chk(exp_q.size() == 0, "queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
